vec_chunk_buffer: RTL and testbench
===================================

Name: vec_chunk_buffer

Overview:
- Double-buffered (ping-pong) vector buffer between two chained matrix-vector layers.
- Write side: collects the serial NBits result stream one element per strobe. This is the upstream layer's req_chunk_out / write_out_data pair.
- Read side: once a full vector is held, presents it as WorkingRegs-wide chunks to the next layer's in_data_ready / req_chunk_in / req_chunk_ptr_rst interface.
- The downstream layer can re-read the whole vector once per output row; the bank is freed only on explicit release.

Parameters:
- VecLength, 16, elements per vector.
- WorkingRegs, 4, elements per read chunk.
- NBits, 12, element width (signed fixed point, 4 integer / 8 fractional).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write strobe, one element per cycle.
- wr_data  input  NBits  signed element.
- out_data_ready  output  1  a full bank is available for reading.
- out_data  output  WorkingRegs*NBits  chunk, packed [WorkingRegs-1:0][NBits-1:0], signed.
- rd_chunk_req  input  1  advance to next chunk.
- rd_ptr_rst  input  1  rewind to chunk 0.
- rd_release  input  1  downstream done with vector; free read bank.
- wr_full  output  1  both banks full; writes are dropped.
- overflow  output  1  sticky; a write was dropped.

Behaviour:
- Reset (async, rst_in low): wr_idx=0, wr_bank=0, rd_bank=0, rd_ptr=0, both bank-full flags 0. All outputs 0, including out_data and overflow. Bank storage contents are not reset.
- Chunks = ceil(VecLength/WorkingRegs). Last-chunk lanes beyond VecLength read as 0.
- Write side:
  - wr_en with wr_bank not full stores wr_data at bank[wr_bank][wr_idx], then wr_idx++.
  - On the write at wr_idx==VecLength-1: set full[wr_bank], toggle wr_bank, wr_idx=0.
  - wr_en while full[wr_bank]=1: data dropped, wr_idx unchanged, overflow<=1 (sticky until reset).
  - wr_full = full[0] & full[1], registered.
- Read side states: EMPTY, PRESENT.
  - EMPTY -> PRESENT when full[rd_bank]=1. out_data loads chunk 0 of rd_bank the same cycle. out_data_ready=1 from the following cycle.
  - In PRESENT:
    - rd_chunk_req: rd_ptr = (rd_ptr==Chunks-1) ? 0 : rd_ptr+1. out_data shows the new chunk next cycle (single-cycle latency, registered output).
    - rd_ptr_rst: rd_ptr=0, chunk 0 on out_data next cycle. Takes precedence over rd_chunk_req in the same cycle.
    - rd_release (highest precedence): clear full[rd_bank], toggle rd_bank, rd_ptr=0, out_data_ready<=0, go to EMPTY. If the other bank is already full, re-enter PRESENT on the next cycle (one bubble cycle, ready low).
  - rd_chunk_req, rd_ptr_rst or rd_release asserted in EMPTY: ignored.
- Simultaneous events:
  - Final write into bank X and rd_release of bank Y in the same cycle: both take effect.
  - Final write completing the bank rd_bank points at while in EMPTY: PRESENT next cycle.
  - Write into a bank being released that same cycle is impossible: writes only target non-full banks.
- Reset mid-vector: partial write contents are discarded; ready drops immediately (async).
- No arithmetic except optional ReLU; widths pass through unchanged.

Optional Feature:
- Macro: VCB_RELU_ON_WRITE_EN.
- Defined: every element is stored as 0 if wr_data[NBits-1]=1, otherwise stored as-is (ReLU between layers, no latency change).
- Undefined: elements are stored unmodified.

Test Plan (VecLength=6, WorkingRegs=4 unless noted):
- Write elements 1..6, then pulse rd_chunk_req once. Required: ready rises 2 cycles after the 6th write; out_data={4,3,2,1}, then {0,0,6,5} one cycle after the request.
- With the above vector held, read both chunks, pulse rd_ptr_rst, read again 3 times. Required: sequence {4,3,2,1},{0,0,6,5},{4,3,2,1},{0,0,6,5},{4,3,2,1}; wrap-around with no release.
- Ping-pong: write vector A=1..6, then B=11..16 while A is read, then pulse rd_release. Required: ready low exactly 1 cycle, then out_data={14,13,12,11}; wr_full never asserted.
- Overflow: write 3 vectors (18 strobes) with no release. Required: wr_full=1 after the 12th write; strobes 13..18 dropped; overflow=1. After release, the next read shows vector 2, not vector 3 data.
- Assert rd_release, rd_ptr_rst and rd_chunk_req together. Required: release wins; rd_ptr=0 and the bank is freed. Also drop rst_in mid-write (3 of 6 elements). Required: outputs 0 asynchronously; after reset a fresh 6-element write presents correctly.
- VCB_RELU_ON_WRITE_EN defined, write {-5,3,-1,7,0,-2}. Required: chunks {7,0,3,0},{0,0,0,0}; without the macro: {7,-1,3,-5},{0,0,-2,0}.

Source files
------------

// File: rtl/vec_chunk_buffer.sv
// Ping-pong vector buffer between two chained matrix-vector layers.
//
// The write side collects a serial stream of NBits signed elements into one of two banks.
// When a bank holds a complete vector, the read side presents it as WorkingRegs-wide chunks.
// The downstream layer may rewind and re-read the vector as often as it likes.
// The bank is freed only when rd_release is pulsed.
//
// Optional build macro: VCB_RELU_ON_WRITE_EN
//   When defined, negative elements are stored as 0 (ReLU).
//   When undefined, elements are stored unmodified.
//
// Ports:
//   clk_in          clock
//   rst_in          asynchronous active-low reset
//   wr_en, wr_data  write strobe and element (one element per cycle)
//   out_data_ready  a full bank is being presented
//   out_data        current chunk, lane 0 = lowest-indexed element
//   rd_chunk_req    advance to the next chunk (wraps after the last one)
//   rd_ptr_rst      rewind to chunk 0
//   rd_release      free the bank being read
//   wr_full         both banks full; writes are dropped
//   overflow        sticky flag, set when a write was dropped
module vec_chunk_buffer #(
  parameter int unsigned VecLength   = 16,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned NBits       = 12
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     wr_en,
  input  logic signed [NBits-1:0]                  wr_data,
  output logic                                     out_data_ready,
  output logic signed [WorkingRegs-1:0][NBits-1:0] out_data,
  input  logic                                     rd_chunk_req,
  input  logic                                     rd_ptr_rst,
  input  logic                                     rd_release,
  output logic                                     wr_full,
  output logic                                     overflow
);

  localparam int unsigned Chunks = (VecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int unsigned IdxW   = (VecLength > 1) ? $clog2(VecLength) : 1;
  localparam int unsigned PtrW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int unsigned LaneW  = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(VecLength - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Chunks - 1);

  typedef enum logic [0:0] {StEmpty, StPresent} state_e;
  typedef logic signed [WorkingRegs-1:0][NBits-1:0] chunk_t;

  state_e state_q, state_d;

  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              wr_full_q;
  logic              overflow_q, overflow_d;
  chunk_t            out_data_q, out_data_d;
  chunk_t            chunk_sel;
  logic              load_chunk;
  logic              wr_accept;
  logic              wr_last;
  logic [NBits-1:0]  store_data;
  int unsigned       elem;

  // Storage is not reset. The full flags alone say which bank holds valid data.
  logic [NBits-1:0] mem_q [2][VecLength];

`ifdef VCB_RELU_ON_WRITE_EN
  assign store_data = wr_data[NBits-1] ? '0 : wr_data;
`else
  assign store_data = wr_data;
`endif

  // Writes only ever target a non-full bank.
  // So the bank being read or released is never written.
  assign wr_accept = wr_en & ~full_q[wr_bank_q];
  assign wr_last   = wr_accept & (wr_idx_q == LastIdx);

  always_ff @(posedge clk_in) begin
    if (wr_accept) begin
      mem_q[wr_bank_q][wr_idx_q] <= store_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:   if (full_q[rd_bank_q]) state_d = StPresent;
      StPresent: if (rd_release)        state_d = StEmpty;
    endcase
  end

  // Ready follows the state register.
  // It rises together with the first chunk and drops immediately on release or reset.
  always_comb begin
    out_data_ready = (state_q == StPresent);
    out_data       = out_data_q;
    wr_full        = wr_full_q;
    overflow       = overflow_q;
  end

  // ---------------------------------------------------------------------------
  // Read pointer, bank flags and write-side bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    load_chunk = 1'b0;
    if (state_q == StEmpty) begin
      if (full_q[rd_bank_q]) begin
        rd_ptr_d   = '0;
        load_chunk = 1'b1;
      end
    end else if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      rd_ptr_d          = '0;
    end else if (rd_ptr_rst) begin
      rd_ptr_d   = '0;
      load_chunk = 1'b1;
    end else if (rd_chunk_req) begin
      rd_ptr_d   = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      load_chunk = 1'b1;
    end
    // A release always targets the read bank, which is full.
    // A final write always targets a non-full bank, so the two never collide.
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    if (wr_en && full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
    end
    if (wr_accept) begin
      if (wr_idx_q == LastIdx) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Chunk at the next pointer value. Lanes past the end of the vector read as zero.
  always_comb begin
    chunk_sel = '0;
    elem      = 0;
    for (int unsigned l = 0; l < WorkingRegs; l++) begin
      elem = 32'(rd_ptr_d) * WorkingRegs + l;
      if (elem < VecLength) begin
        chunk_sel[LaneW'(l)] = mem_q[rd_bank_q][elem[IdxW-1:0]];
      end
    end
  end

  always_comb begin
    out_data_d = load_chunk ? chunk_sel : out_data_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      full_q     <= 2'b00;
      wr_full_q  <= 1'b0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      wr_full_q  <= full_d[0] & full_d[1];
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// Bench for vec_chunk_buffer (VecLength=6, WorkingRegs=4, NBits=12).
// Reference model: a FIFO of completed vectors with capacity 2, plus one partial vector.
// Directed scenarios pin the model with literal chunks.
// A random phase follows.
// One compare process checks every output on every negedge.
module tb_vec_chunk_buffer;

  localparam int VL = 6;
  localparam int WR = 4;
  localparam int NB = 12;
  localparam int CH = (VL + WR - 1) / WR;

  typedef logic [VL-1:0][NB-1:0] vec_t;
  typedef logic [WR-1:0][NB-1:0] chunk_t;

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b1;
  logic                        wr_en = 1'b0;
  logic signed [NB-1:0]        wr_data = '0;
  logic                        rd_chunk_req = 1'b0;
  logic                        rd_ptr_rst = 1'b0;
  logic                        rd_release = 1'b0;
  logic                        out_data_ready;
  logic signed [WR-1:0][NB-1:0] out_data;
  logic                        wr_full;
  logic                        overflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  vec_t   fifo[$];
  vec_t   part;
  int     m_cnt;
  bit     m_present;
  int     m_ptr;
  chunk_t m_out;
  bit     m_ovf;
  bit     m_wrfull;

  vec_chunk_buffer #(
    .VecLength  (VL),
    .WorkingRegs(WR),
    .NBits      (NB)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .out_data_ready(out_data_ready),
    .out_data      (out_data),
    .rd_chunk_req  (rd_chunk_req),
    .rd_ptr_rst    (rd_ptr_rst),
    .rd_release    (rd_release),
    .wr_full       (wr_full),
    .overflow      (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic chunk_t pk(input int a, input int b, input int c, input int d);
    chunk_t r;
    r[0] = NB'(a);
    r[1] = NB'(b);
    r[2] = NB'(c);
    r[3] = NB'(d);
    return r;
  endfunction

  function automatic chunk_t model_chunk(input vec_t v, input int p);
    chunk_t c = '0;
    for (int l = 0; l < WR; l++) begin
      if (p * WR + l < VL) c[l] = v[p * WR + l];
    end
    return c;
  endfunction

  function automatic logic [NB-1:0] relu(input logic [NB-1:0] d);
`ifdef VCB_RELU_ON_WRITE_EN
    return d[NB-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    fifo.delete();
    part      = '0;
    m_cnt     = 0;
    m_present = 1'b0;
    m_ptr     = 0;
    m_out     = '0;
    m_ovf     = 1'b0;
    m_wrfull  = 1'b0;
  endtask

  // One clock edge of the reference model.
  // Every decision uses the state from before the edge.
  task automatic model_step(input bit en, input logic [NB-1:0] d, input bit req, input bit prst,
                            input bit rel);
    int pre;
    pre = fifo.size();
    if (!m_present) begin
      if (pre > 0) begin
        m_present = 1'b1;
        m_ptr     = 0;
        m_out     = model_chunk(fifo[0], 0);
      end
    end else if (rel) begin
      void'(fifo.pop_front());
      m_present = 1'b0;
      m_ptr     = 0;
    end else if (prst) begin
      m_ptr = 0;
      m_out = model_chunk(fifo[0], 0);
    end else if (req) begin
      m_ptr = (m_ptr + 1) % CH;
      m_out = model_chunk(fifo[0], m_ptr);
    end
    if (en) begin
      if (pre == 2) begin
        m_ovf = 1'b1;
      end else begin
        part[m_cnt] = relu(d);
        m_cnt++;
        if (m_cnt == VL) begin
          fifo.push_back(part);
          m_cnt = 0;
        end
      end
    end
    m_wrfull = (fifo.size() == 2);
  endtask

  task automatic step(input bit en, input int d, input bit req, input bit prst, input bit rel);
    wr_en        = en;
    wr_data      = NB'(d);
    rd_chunk_req = req;
    rd_ptr_rst   = prst;
    rd_release   = rel;
    @(posedge clk_in);
    model_step(en, NB'(d), req, prst, rel);
    @(negedge clk_in);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare process
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("ready", 64'(out_data_ready), 64'(m_present));
      check("out_data", {16'b0, out_data}, {16'b0, m_out});
      check("wr_full", 64'(wr_full), 64'(m_wrfull));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(out_data_ready), 64'd0);
    check({tag, "_out_data"}, {16'b0, out_data}, 64'd0);
    check({tag, "_wr_full"}, 64'(wr_full), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    model_reset();
    #1 rst_in = 1'b0;
    #3 check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 chk_en = 1'b1;

    // Single vector: ready rises two cycles after the last write.
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("ready_low_after_last_write", 64'(out_data_ready), 64'd0);
    idle();
    check("ready_rise", 64'(out_data_ready), 64'd1);
    check("first_chunk0", {16'b0, out_data}, {16'b0, pk(1, 2, 3, 4)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("first_chunk1", {16'b0, out_data}, {16'b0, pk(5, 6, 0, 0)});

    // Rewind and wrap-around without release.
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("rewind_chunk0", {16'b0, out_data}, {16'b0, pk(1, 2, 3, 4)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("reread_chunk1", {16'b0, out_data}, {16'b0, pk(5, 6, 0, 0)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("wrap_chunk0", {16'b0, out_data}, {16'b0, pk(1, 2, 3, 4)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("wrap_chunk1", {16'b0, out_data}, {16'b0, pk(5, 6, 0, 0)});

    // Ping-pong: write B while A is read; release coincides with B's last write.
    for (int i = 1; i <= 5; i++) step(1'b1, 10 + i, i[0], 1'b0, 1'b0);
    step(1'b1, 16, 1'b0, 1'b0, 1'b1);
    check("pingpong_bubble", 64'(out_data_ready), 64'd0);
    check("pingpong_no_wr_full", 64'(wr_full), 64'd0);
    idle();
    check("pingpong_ready", 64'(out_data_ready), 64'd1);
    check("pingpong_chunk0", {16'b0, out_data}, {16'b0, pk(11, 12, 13, 14)});

    // Overflow: 18 strobes with no release; strobes 13..18 are dropped.
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 20 + i, 1'b0, 1'b0, 1'b0);
      if (i == 11) check("wr_full_before_12", 64'(wr_full), 64'd0);
      if (i == 12) check("wr_full_after_12", 64'(wr_full), 64'd1);
    end
    check("overflow_set", 64'(overflow), 64'd1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("wr_full_cleared", 64'(wr_full), 64'd0);
    idle();
    check("after_overflow_vec2", {16'b0, out_data}, {16'b0, pk(27, 28, 29, 30)});

    // Release beats rewind and advance when all three are asserted together.
    step(1'b0, 0, 1'b1, 1'b1, 1'b1);
    check("combo_ready_low", 64'(out_data_ready), 64'd0);
    idle();
    check("combo_stays_empty", 64'(out_data_ready), 64'd0);
    for (int i = 1; i <= 6; i++) step(1'b1, 50 + i, 1'b0, 1'b0, 1'b0);
    idle();
    check("combo_next_vec_chunk0", {16'b0, out_data}, {16'b0, pk(51, 52, 53, 54)});

    // Asynchronous reset in the middle of a vector.
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b1, 60 + i, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b0;
    #2 rst_in = 1'b0;
    #1 check_all_zero("async_reset");
    chk_en = 1'b0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 chk_en = 1'b1;
    for (int i = 1; i <= 6; i++) step(1'b1, 40 + i, 1'b0, 1'b0, 1'b0);
    idle();
    check("post_reset_ready", 64'(out_data_ready), 64'd1);
    check("post_reset_chunk0", {16'b0, out_data}, {16'b0, pk(41, 42, 43, 44)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("post_reset_chunk1", {16'b0, out_data}, {16'b0, pk(45, 46, 0, 0)});

    // Signed elements: ReLU behaviour depends on the build macro.
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, -5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, -1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, -2, 1'b0, 1'b0, 1'b0);
    idle();
`ifdef VCB_RELU_ON_WRITE_EN
    check("relu_chunk0", {16'b0, out_data}, {16'b0, pk(0, 3, 0, 7)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("relu_chunk1", {16'b0, out_data}, {16'b0, pk(0, 0, 0, 0)});
`else
    check("signed_chunk0", {16'b0, out_data}, {16'b0, pk(-5, 3, -1, 7)});
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("signed_chunk1", {16'b0, out_data}, {16'b0, pk(0, -2, 0, 0)});
`endif

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 4095)),
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
           $urandom_range(0, 9) < 1);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
